// File: rtl/seq_pkg.sv
// Shared definitions for the pattern-entry puzzle: phase encoding and the
// target pattern, so the player and the checker agree on one source.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seqState_t;

  localparam int SEQ_WIDTH = 6;

  // bit 0 is played first
  localparam logic [SEQ_WIDTH-1:0] SEQ_PATTERN = 6'b100101;

endpackage

// File: rtl/sequence_player_phase_timer.sv
// Loadable down-counter used to time both the SHOW and the GAP phases.
// A load always wins; otherwise the count steps down and parks at zero.
module phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] loadValue,
  output logic          zero
);

  logic [TW-1:0] count_r;

  // Reload on every phase entry, otherwise count down without wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {TW{1'b0}};
    end else if (load) begin
      count_r <= loadValue;
    end else if (count_r != {TW{1'b0}}) begin
      count_r <= count_r - {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count_r == {TW{1'b0}});

endmodule

// File: rtl/sequence_player.sv
// Plays PATTERN bit-by-bit on one LED (bit 0 first) with timed show/gap
// phases, then holds "done" until cleared or restarted. All outputs are
// registered and decoded from the next state so they change on the same
// edge as the state itself.
module sequence_player
  import seq_pkg::*;
#(
  parameter int               WIDTH       = SEQ_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN     = SEQ_PATTERN,
  parameter int               STEP_CYCLES = 50_000_000,
  parameter int               GAP_CYCLES  = 12_500_000,
  localparam int              IDXW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  output logic             led_bit,
  output logic             led_valid,
  output logic [IDXW-1:0]  bit_index,
  output logic [WIDTH-1:0] pattern_out,
  output logic             busy,
  output logic             done
);

  localparam int MAX_CYCLES = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0]   STEP_LOAD = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0]   GAP_LOAD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : {TW{1'b0}};
  localparam logic            HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] IDX_ONE   = {{(IDXW-1){1'b0}}, 1'b1};

  seqState_t       state_r;
  seqState_t       nextState_s;
  logic [IDXW-1:0] bitIdx_r;
  logic [IDXW-1:0] nextIdx_s;
  logic            timerLoad_s;
  logic [TW-1:0]   loadValue_s;
  logic            timerZero_s;

  phase_timer #(
    .TW(TW)
  ) uTimer (
    .clk       (clk),
    .reset     (reset),
    .load      (timerLoad_s),
    .loadValue (loadValue_s),
    .zero      (timerZero_s)
  );

  // State and bit-index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      bitIdx_r <= {IDXW{1'b0}};
    end else begin
      state_r  <= nextState_s;
      bitIdx_r <= nextIdx_s;
    end
  end

  // Next-state, next-index and timer-load decisions
  always_comb begin
    nextState_s = state_r;
    nextIdx_s   = bitIdx_r;
    timerLoad_s = 1'b0;
    loadValue_s = STEP_LOAD;
    case (state_r)
      IDLE: begin
        if (start) begin
          nextState_s = SHOW;
          nextIdx_s   = {IDXW{1'b0}};
          timerLoad_s = 1'b1;
        end else begin
          nextState_s = IDLE;
        end
      end
      SHOW: begin
        if (timerZero_s) begin
          if (bitIdx_r == LAST_IDX) begin
            nextState_s = DONE;
          end else if (HAS_GAP) begin
            nextState_s = GAP;
            timerLoad_s = 1'b1;
            loadValue_s = GAP_LOAD;
          end else begin
            nextState_s = SHOW;
            nextIdx_s   = bitIdx_r + IDX_ONE;
            timerLoad_s = 1'b1;
          end
        end else begin
          nextState_s = SHOW;
        end
      end
      GAP: begin
        if (timerZero_s) begin
          nextState_s = SHOW;
          nextIdx_s   = bitIdx_r + IDX_ONE;
          timerLoad_s = 1'b1;
        end else begin
          nextState_s = GAP;
        end
      end
      DONE: begin
        // start beats clear when both arrive together
        if (start) begin
          nextState_s = SHOW;
          nextIdx_s   = {IDXW{1'b0}};
          timerLoad_s = 1'b1;
        end else if (clear) begin
          nextState_s = IDLE;
          nextIdx_s   = {IDXW{1'b0}};
        end else begin
          nextState_s = DONE;
        end
      end
      default: begin
        nextState_s = IDLE;
        nextIdx_s   = {IDXW{1'b0}};
      end
    endcase
  end

  // Output registers decoded from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      led_valid   <= 1'b0;
      led_bit     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pattern_out <= PATTERN;
    end else begin
      led_valid   <= (nextState_s == SHOW);
      led_bit     <= (nextState_s == SHOW) ? PATTERN[nextIdx_s] : 1'b0;
      busy        <= (nextState_s == SHOW) || (nextState_s == GAP);
      done        <= (nextState_s == DONE);
      pattern_out <= PATTERN;
    end
  end

  assign bit_index = bitIdx_r;

endmodule
